d_mem_arbiter: RTL and testbench

- Arbitrates the single-ported byte-strobed data memory between two requesters: port 0 is the core load/store unit, port 1 is the boot/debug loader.
- Uses valid/ready on the request side and a fixed one-cycle response pulse on the response side.
- Pre-checks every request against the memory's base/bound window and the legal write-strobe set; violating requests are answered with an error and never reach memory.
- Sits between the core/loader and the data memory; drives its enable/read/strobe/address/store inputs and routes its registered fetch data back.

---
 rtl/d_mem_arb_pkg.sv | 40 ++++
 rtl/d_mem_rr_arb.sv | 41 ++++
 rtl/d_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_d_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_mem_arb_pkg.sv
// Shared constants, request payload and strobe-legality helper for the data memory arbiter.
package d_mem_arb_pkg;

    localparam int unsigned NUM_PORTS      = 2;
    localparam int unsigned PORT_CORE      = 0;
    localparam int unsigned PORT_LOADER    = 1;
    localparam int unsigned REQ_ADDR_W     = 32;
    localparam int unsigned REQ_DATA_W     = 32;
    localparam int unsigned STRB_W         = REQ_DATA_W / 8;
    localparam int unsigned NUM_LEGAL_STRB = 7;

    // Byte, aligned halfword and full word store patterns.
    localparam logic [STRB_W-1:0] LEGAL_STRB [NUM_LEGAL_STRB] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
    };

    typedef struct packed {
        logic                  write;
        logic [STRB_W-1:0]     wstrb;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        FAV_CORE   = 1'b0,
        FAV_LOADER = 1'b1
    } rr_state_e;

    function automatic logic strb_legal(input logic [STRB_W-1:0] strb);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_LEGAL_STRB; i++) begin
            if (strb == LEGAL_STRB[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/d_mem_rr_arb.sv
// Two-way round-robin grant; the favoured port flips to the other side on every accept.
module d_mem_rr_arb
    import d_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant_c
);

    rr_state_e state;
    rr_state_e state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FAV_CORE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is suppressed during reset so nothing can be accepted.
    always_comb begin
        grant_c    = 2'b00;
        state_next = state;
        if (!rst) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = (state == FAV_CORE) ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
        if (grant_c[PORT_CORE]) begin
            state_next = FAV_LOADER;
        end else if (grant_c[PORT_LOADER]) begin
            state_next = FAV_CORE;
        end
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// Data memory arbiter: core LSU (port 0) and boot/debug loader (port 1) share one memory port.
// Optional performance counters are enabled with the D_MEM_ARB_PERF_EN macro.
module d_mem_arbiter
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = REQ_ADDR_W,
    parameter int unsigned DATA_W = REQ_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_write,
    input  logic [1:0][DATA_W/8-1:0]      req_wstrb,
    input  logic [1:0][ADDR_W-1:0]        req_addr,
    input  logic [1:0][DATA_W-1:0]        req_wdata,
    output logic [1:0]                    rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    input  logic [ADDR_W-1:0]             bound_base,
    input  logic [ADDR_W-1:0]             bound_limit,
    output logic                          mem_enable,
    output logic                          mem_read,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
`ifdef D_MEM_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_grant0,
    output logic [31:0]                   perf_grant1,
    output logic [31:0]                   perf_conflict,
    output logic [31:0]                   perf_err
`endif
);

    localparam int unsigned MEM_STRB_W = DATA_W / 8;

    logic [1:0]  grant;
    mem_req_t    req_pkt [NUM_PORTS];
    mem_req_t    sel_req;
    logic        sel_port;
    logic        accept;
    logic        in_bounds;
    logic        legal;
    logic        ok;
    logic [ADDR_W-1:0] sel_addr;

    logic        pend_valid;
    logic        pend_port;
    logic        pend_err;
    logic        pend_read;
    logic        rsp_live;

    d_mem_rr_arb u_rr_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .grant_c (grant)
    );

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_pkt[i] = '{
                write: req_write[i],
                wstrb: STRB_W'(req_wstrb[i]),
                addr:  REQ_ADDR_W'(req_addr[i]),
                wdata: REQ_DATA_W'(req_wdata[i])
            };
        end
    end

    // Window and strobe checks apply only to the request actually granted this cycle.
    always_comb begin
        sel_port  = grant[PORT_LOADER];
        sel_req   = req_pkt[sel_port];
        sel_addr  = ADDR_W'(sel_req.addr);
        accept    = |grant;
        in_bounds = (sel_addr >= bound_base) && (sel_addr <= bound_limit);
        legal     = !sel_req.write || strb_legal(sel_req.wstrb);
        ok        = in_bounds && legal;
    end

    assign req_ready = grant;

    always_comb begin
        mem_enable = accept && ok;
        mem_read   = !sel_req.write;
        mem_addr   = sel_addr;
        mem_wdata  = DATA_W'(sel_req.wdata);
        mem_wstrb  = mem_enable ? MEM_STRB_W'(sel_req.wstrb) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_port  <= 1'b0;
            pend_err   <= 1'b0;
            pend_read  <= 1'b0;
        end else begin
            pend_valid <= accept;
            pend_port  <= sel_port;
            pend_err   <= !ok;
            pend_read  <= !sel_req.write;
        end
    end

    // Gating with rst drops a response that was pending when reset rose.
    always_comb begin
        rsp_live  = pend_valid && !rst;
        rsp_valid = rsp_live ? (pend_port ? 2'b10 : 2'b01) : 2'b00;
        rsp_err   = rsp_live && pend_err;
        rsp_rdata = (rsp_live && !pend_err && pend_read) ? mem_rdata : '0;
    end

`ifdef D_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
            perf_err      <= '0;
        end else begin
            if (grant[PORT_CORE]) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (grant[PORT_LOADER]) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if (&req_valid) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (accept && !ok) begin
                perf_err <= perf_err + 32'd1;
            end
        end
    end
`else
    // Default build: no performance counters are instantiated.
`endif

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Self-checking bench for d_mem_arbiter: directed scenarios then random traffic against a reference model.
module tb_d_mem_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [1:0][3:0]   req_wstrb;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       bound_base;
    logic [31:0]       bound_limit;
    logic              mem_enable;
    logic              mem_read;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
`ifdef D_MEM_ARB_PERF_EN
    logic [31:0]       perf_grant0;
    logic [31:0]       perf_grant1;
    logic [31:0]       perf_conflict;
    logic [31:0]       perf_err;
`endif

    always #5 clk = ~clk;

    d_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_wstrb   (req_wstrb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bound_base  (bound_base),
        .bound_limit (bound_limit),
        .mem_enable  (mem_enable),
        .mem_read    (mem_read),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef D_MEM_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict),
        .perf_err      (perf_err)
`endif
    );

    // Environment memory driven by the DUT, word-indexed, registered read data.
    logic [31:0] env_mem [int unsigned];

    always @(posedge clk) begin
        logic [31:0] word;
        if (mem_enable === 1'b1) begin
            word = env_mem.exists(mem_addr >> 2) ? env_mem[mem_addr >> 2] : 32'h0;
            if (mem_read) begin
                mem_rdata <= word;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                env_mem[mem_addr >> 2] = word;
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [int unsigned];
    int          last_grant = 1;
    bit          pv = 1'b0;
    int          pport = 0;
    bit          perr = 1'b0;
    logic [31:0] prdata = 32'h0;
    int unsigned m_g0 = 0, m_g1 = 0, m_conf = 0, m_err = 0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit strb_ok(input logic [3:0] s);
        return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    endfunction

    // One clock cycle: drive, check responses and issue, then advance the model at the edge.
    task automatic step(input bit r, input logic [1:0] v, input logic [1:0] w,
                        input logic [3:0] s0, input logic [3:0] s1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        int          g;
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          wr, ok, npv, nerr;
        logic [31:0] nrd, word;
        logic [1:0]  exp_rv;

        rst = r; req_valid = v; req_write = w;
        req_wstrb[0] = s0; req_wstrb[1] = s1;
        req_addr[0] = a0;  req_addr[1] = a1;
        req_wdata[0] = d0; req_wdata[1] = d1;
        #1;

        exp_rv = (!r && pv) ? ((pport == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_err", 32'(rsp_err), 32'((!r && pv) ? perr : 1'b0));
        chk("rsp_rdata", rsp_rdata, (!r && pv) ? prdata : 32'h0);
        last_rdata = rsp_rdata;
        last_ready = req_ready;

        g = -1;
        if (!r) begin
            if (v == 2'b11)      g = 1 - last_grant;
            else if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
        end
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'h0 : (32'h1 << g));

        ok = 1'b0; wr = 1'b0; a = 32'h0; d = 32'h0; s = 4'h0;
        if (g >= 0) begin
            a  = (g == 1) ? a1 : a0;
            d  = (g == 1) ? d1 : d0;
            s  = (g == 1) ? s1 : s0;
            wr = w[g];
            ok = (a >= bound_base) && (a <= bound_limit) && (!wr || strb_ok(s));
        end
        chk("mem_enable", 32'(mem_enable), 32'(ok));
        if (ok) begin
            chk("mem_addr", mem_addr, a);
            chk("mem_read", 32'(mem_read), 32'(!wr));
            if (wr) begin
                chk("mem_wstrb", 32'(mem_wstrb), 32'(s));
                chk("mem_wdata", mem_wdata, d);
            end
        end else begin
            chk("mem_wstrb_idle", 32'(mem_wstrb), 32'h0);
        end

        npv  = (g >= 0);
        nerr = !ok;
        nrd  = (ok && !wr) ? ref_read(a) : 32'h0;
        if (ok && wr) begin
            word = ref_read(a);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) word[8*b +: 8] = d[8*b +: 8];
            end
            ref_mem[a >> 2] = word;
        end

        if (r) begin
            last_grant = 1;
            m_g0 = 0; m_g1 = 0; m_conf = 0; m_err = 0;
        end else begin
            if (g == 0) m_g0++;
            if (g == 1) m_g1++;
            if (v == 2'b11) m_conf++;
            if (g >= 0 && !ok) m_err++;
            if (g >= 0) last_grant = g;
        end

        @(posedge clk);
        pv = npv; pport = g; perr = nerr; prdata = nrd;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        bound_base  = 32'h0;
        bound_limit = 32'h400;

        // Reset with both ports requesting: nothing may be granted.
        step(1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 32'h100, 32'h104, 32'h0, 32'h0);
        chk("reset_ready", 32'(last_ready), 32'h0);
        step(1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 32'h100, 32'h104, 32'h0, 32'h0);

        // Conflict: four back-to-back cycles, second loader access out of bounds.
        step(1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h100, 32'h104, 32'h0, 32'h0);
        chk("conf_g0", 32'(last_ready), 32'h1);
        step(1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h100, 32'h404, 32'h0, 32'h0);
        chk("conf_g1", 32'(last_ready), 32'h2);
        step(1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h108, 32'h10c, 32'h0, 32'h0);
        chk("conf_g2", 32'(last_ready), 32'h1);
        step(1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h108, 32'h10c, 32'h0, 32'h0);
        chk("conf_g3", 32'(last_ready), 32'h2);
`ifdef D_MEM_ARB_PERF_EN
        chk("perf_grant0", perf_grant0, 32'd2);
        chk("perf_grant1", perf_grant1, 32'd2);
        chk("perf_conflict", perf_conflict, 32'd4);
        chk("perf_err", perf_err, 32'd1);
`endif
        idle();

        // Round trip on the core port.
        step(1'b0, 2'b01, 2'b01, 4'hF, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
        step(1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0);
        idle();
        chk("roundtrip_rdata", last_rdata, 32'hDEADBEEF);

        // Out-of-bounds loader load, then the inclusive upper limit.
        step(1'b0, 2'b10, 2'b00, 4'h0, 4'h0, 32'h0, 32'h404, 32'h0, 32'h0);
        chk("oob_ready", 32'(last_ready), 32'h2);
        step(1'b0, 2'b10, 2'b00, 4'h0, 4'h0, 32'h0, 32'h400, 32'h0, 32'h0);
        idle();

        // Illegal strobe leaves memory untouched.
        step(1'b0, 2'b01, 2'b01, 4'hF, 4'h0, 32'h20, 32'h0, 32'h11223344, 32'h0);
        step(1'b0, 2'b01, 2'b01, 4'b0110, 4'h0, 32'h20, 32'h0, 32'hAAAAAAAA, 32'h0);
        step(1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h20, 32'h0, 32'h0, 32'h0);
        idle();
        chk("badstrb_rdata", last_rdata, 32'h11223344);

        // Inverted window: every access errors.
        bound_base  = 32'h200;
        bound_limit = 32'h100;
        step(1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h180, 32'h0, 32'h0, 32'h0);
        idle();
        bound_base  = 32'h0;
        bound_limit = 32'h400;

        // Reset while a core load response is pending.
        step(1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0);
        step(1'b1, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0);
        chk("post_rst_grant", 32'(last_ready), 32'h1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) begin
                bound_base  = 32'($urandom_range(0, 32'h100)) << 2;
                bound_limit = 32'($urandom_range(0, 32'h140)) << 2;
            end
            step(($urandom_range(0, 49) == 0),
                 2'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom),
                 32'($urandom_range(0, 32'h140)) << 2,
                 32'($urandom_range(0, 32'h140)) << 2,
                 $urandom, $urandom);
        end
        idle();

`ifdef D_MEM_ARB_PERF_EN
        chk("perf_grant0_end", perf_grant0, 32'(m_g0));
        chk("perf_grant1_end", perf_grant1, 32'(m_g1));
        chk("perf_conflict_end", perf_conflict, 32'(m_conf));
        chk("perf_err_end", perf_err, 32'(m_err));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
